// File: rtl/shift_counter_pkg.sv
// shift_counter_pkg: mode constants and phase-to-pattern decode helpers for shift_counter_gen
package shift_counter_pkg;
  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING = 1'b1;
  function automatic logic [31:0] johnson_decode(input int unsigned w, input int unsigned k);
    logic [63:0] ones;
    ones = k <= w ? (64'd1 << w) - (64'd1 << (w - k)) : (64'd1 << (2 * w - k)) - 64'd1;
    return ones[31:0];
  endfunction
  function automatic logic [31:0] ring_decode(input int unsigned w, input int unsigned k);
    return k == 0 ? 32'd1 : 32'd1 << (w - k);
  endfunction
endpackage

// File: rtl/shift_phase_decoder.sv
// shift_phase_decoder: combinational phase index to shift pattern (Johnson or one-hot ring)
// ports: mode (0 Johnson, 1 ring), phase (index < MOD), pattern (WIDTH-bit shift pattern)
module shift_phase_decoder
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic mode,
  input  logic [PW-1:0] phase,
  output logic [WIDTH-1:0] pattern
);
  assign pattern = mode == MODE_RING ? WIDTH'(ring_decode(WIDTH, 32'(phase)))
                                     : WIDTH'(johnson_decode(WIDTH, 32'(phase)));
endmodule

// File: rtl/shift_counter_gen.sv
// shift_counter_gen: Johnson / one-hot ring sequence generator with phase index and wrap pulse
// ports: clk, rst (async active-low), en, dir (1 up), mode (0 Johnson, 1 ring), load, load_phase,
//        count (pattern), phase (index), wrap (modulus wrap pulse), load_err (rejected load pulse)
module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic dir,
  input  logic mode,
  input  logic load,
  input  logic [PW-1:0] load_phase,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0] phase,
  output logic wrap,
  output logic load_err
);
  localparam logic [PW:0] MOD_J = (PW + 1)'(2 * WIDTH);
  localparam logic [PW:0] MOD_R = (PW + 1)'(WIDTH);
  logic mode_q, mode_d, load_ok, switching, at_top, at_zero, wrap_d, err_d;
  logic [PW:0] mod_q, mod_in;
  logic [PW-1:0] top, stepped, phase_d;
  logic [WIDTH-1:0] count_d;
  always_comb begin
    mod_q = mode_q ? MOD_R : MOD_J;
    mod_in = mode ? MOD_R : MOD_J;
    top = PW'(mod_q - 1'b1);
    at_top = phase == top;
    at_zero = phase == '0;
    load_ok = {1'b0, load_phase} < mod_in;
    switching = mode != mode_q;
    stepped = dir ? (at_top ? '0 : phase + PW'(1)) : (at_zero ? top : phase - PW'(1));
    phase_d = load ? (load_ok ? load_phase : phase) : switching ? '0 : en ? stepped : phase;
    mode_d = load && !load_ok ? mode_q : mode;
    wrap_d = !load && !switching && en && (dir ? at_top : at_zero);
    err_d = load && !load_ok;
  end
  // decode the next phase so count lands in the same edge as phase
  shift_phase_decoder #(.WIDTH(WIDTH)) u_dec (
    .mode(mode_d),
    .phase(phase_d),
    .pattern(count_d)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
      mode_q <= MODE_JOHNSON;
      count <= '0;
      wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      phase <= phase_d;
      mode_q <= mode_d;
      count <= count_d;
      wrap <= wrap_d;
      load_err <= err_d;
    end
  end
endmodule

// File: tb/tb_shift_counter_gen.sv
// tb_shift_counter_gen: directed plus random checks of WIDTH=4 and WIDTH=5 generators against a model
module tb_shift_counter_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_en[2], in_dir[2], in_mode[2], in_load[2];
  logic [3:0] in_lp[2];
  logic [3:0] c4;
  logic [2:0] p4;
  logic [4:0] c5;
  logic [3:0] p5;
  logic w4, e4, w5, e5;
  int checks = 0;
  int failures = 0;
  int mp[2], mm[2], mw[2], me[2];
  int exp1[9] = '{8, 12, 14, 15, 7, 3, 1, 0, 8};
  always #5 clk = ~clk;
  shift_counter_gen #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(in_en[0]), .dir(in_dir[0]), .mode(in_mode[0]),
    .load(in_load[0]), .load_phase(in_lp[0][2:0]),
    .count(c4), .phase(p4), .wrap(w4), .load_err(e4)
  );
  shift_counter_gen #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .en(in_en[1]), .dir(in_dir[1]), .mode(in_mode[1]),
    .load(in_load[1]), .load_phase(in_lp[1]),
    .count(c5), .phase(p5), .wrap(w5), .load_err(e5)
  );
  function automatic logic [31:0] mdec(int w, int m, int k);
    logic [31:0] r = '0;
    for (int b = 0; b < w; b++)
      r[b] = m != 0 ? (b == (w - k) % w) : (k <= w ? b >= w - k : b < 2 * w - k);
    return r;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mp[i] = 0; mm[i] = 0; mw[i] = 0; me[i] = 0;
    end
  endtask
  task automatic model_edge(int i);
    int w = i == 0 ? 4 : 5;
    int modq = mm[i] != 0 ? w : 2 * w;
    int modin = in_mode[i] ? w : 2 * w;
    mw[i] = 0;
    me[i] = 0;
    if (in_load[i]) begin
      if (int'(in_lp[i]) < modin) begin
        mp[i] = int'(in_lp[i]);
        mm[i] = int'(in_mode[i]);
      end else me[i] = 1;
    end else if (int'(in_mode[i]) != mm[i]) begin
      mm[i] = int'(in_mode[i]);
      mp[i] = 0;
    end else if (in_en[i]) begin
      if (in_dir[i]) begin
        mw[i] = int'(mp[i] == modq - 1);
        mp[i] = (mp[i] + 1) % modq;
      end else begin
        mw[i] = int'(mp[i] == 0);
        mp[i] = (mp[i] + modq - 1) % modq;
      end
    end
  endtask
  task automatic check_all();
    chk("w4_count", 32'(c4), mdec(4, mm[0], mp[0]));
    chk("w4_phase", 32'(p4), 32'(mp[0]));
    chk("w4_wrap", 32'(w4), 32'(mw[0]));
    chk("w4_load_err", 32'(e4), 32'(me[0]));
    chk("w5_count", 32'(c5), mdec(5, mm[1], mp[1]));
    chk("w5_phase", 32'(p5), 32'(mp[1]));
    chk("w5_wrap", 32'(w5), 32'(mw[1]));
    chk("w5_load_err", 32'(e5), 32'(me[1]));
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      in_en[i] = 0; in_dir[i] = 0; in_mode[i] = 0; in_load[i] = 0; in_lp[i] = '0;
    end
    model_reset();
    #3;
    check_all();
    chk("reset_count", 32'(c4), 32'd0);
    #10 rst = 1'b1;
    in_en[0] = 1; in_dir[0] = 1;
    for (int j = 0; j < 9; j++) begin
      tick();
      chk("t1_count", 32'(c4), 32'(exp1[j]));
      chk("t1_wrap", 32'(w4), 32'(j == 7));
    end
    in_dir[0] = 0;
    tick();
    chk("t2_pre_phase", 32'(p4), 32'd0);
    tick();
    chk("t2_count_a", 32'(c4), 32'd1);
    chk("t2_phase_a", 32'(p4), 32'd7);
    chk("t2_wrap_a", 32'(w4), 32'd1);
    tick();
    chk("t2_count_b", 32'(c4), 32'd3);
    chk("t2_phase_b", 32'(p4), 32'd6);
    chk("t2_wrap_b", 32'(w4), 32'd0);
    in_mode[0] = 1;
    tick();
    chk("t3_switch_count", 32'(c4), 32'd1);
    chk("t3_switch_phase", 32'(p4), 32'd0);
    in_dir[0] = 1;
    tick(); chk("t3_ring_1", 32'(c4), 32'd8);
    tick(); chk("t3_ring_2", 32'(c4), 32'd4);
    tick(); chk("t3_ring_3", 32'(c4), 32'd2);
    tick();
    chk("t3_ring_4", 32'(c4), 32'd1);
    chk("t3_ring_wrap", 32'(w4), 32'd1);
    in_en[0] = 0; in_load[0] = 1; in_lp[0] = 4'd5;
    tick();
    chk("t4_reject_err", 32'(e4), 32'd1);
    chk("t4_reject_phase", 32'(p4), 32'd0);
    chk("t4_reject_count", 32'(c4), 32'd1);
    in_mode[0] = 0;
    tick();
    chk("t4_load_phase", 32'(p4), 32'd5);
    chk("t4_load_count", 32'(c4), 32'd7);
    chk("t4_load_err", 32'(e4), 32'd0);
    in_en[0] = 1; in_lp[0] = 4'd2;
    tick();
    chk("t5_phase", 32'(p4), 32'd2);
    chk("t5_count", 32'(c4), 32'd12);
    chk("t5_wrap", 32'(w4), 32'd0);
    in_load[0] = 0;
    for (int j = 0; j < 4; j++) tick();
    chk("t6_pre_phase", 32'(p4), 32'd6);
    in_en[0] = 0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6_async_count", 32'(c4), 32'd0);
    chk("t6_async_phase", 32'(p4), 32'd0);
    in_mode[0] = 1;
    #1 rst = 1'b1;
    tick();
    chk("t6_release_count", 32'(c4), 32'd1);
    in_en[1] = 1; in_dir[1] = 1;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("t6_w5_wrap", 32'(w5), 32'(j == 9));
    end
    chk("t6_w5_phase", 32'(p5), 32'd0);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        in_en[i] = $urandom_range(0, 3) != 0;
        in_dir[i] = 1'($urandom);
        if ($urandom_range(0, 15) == 0) in_mode[i] = ~in_mode[i];
        in_load[i] = $urandom_range(0, 7) == 0;
        in_lp[i] = i == 0 ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
      end
      if (n == 200) begin
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_all();
        rst = 1'b1;
      end
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
